// File: rtl/adc_sequencer.sv
// Scanning sequencer for an 8-channel serial ADC with a pipelined address/data protocol.
// Each frame sends the next channel address while reading back the conversion addressed by the previous frame.
module adc_sequencer #(
  parameter int SCLK_DIV   = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        continuous,
  input  logic [7:0]  ch_mask,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic [11:0] sample_data,
  output logic [2:0]  sample_ch,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] SHIFT    = 3'd2;
  localparam logic [2:0] GAP      = 3'd3;
  localparam logic [2:0] WAIT_ACK = 3'd4;

  localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  logic [2:0]  state;
  logic [7:0]  div_cnt;
  logic [7:0]  gap_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  mask;
  logic [2:0]  addr_ch;
  logic [2:0]  data_ch;
  logic        data_valid;
  logic [3:0]  remaining;
  logic [11:0] shreg;
  logic        accept;
  logic        free;
  logic        proceed;

  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Next enabled channel strictly after c, wrapping; returns c itself when it is the only one.
  function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] c);
    logic [2:0] r;
    logic [2:0] k;
    logic       found;
    r     = c;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      k = c + 3'(i);
      if (!found && m[k]) begin
        r     = k;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic addr_bit(input logic [3:0] b, input logic [2:0] a);
    logic r;
    case (b)
      4'd2:    r = a[2];
      4'd3:    r = a[1];
      4'd4:    r = a[0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign accept  = sample_valid && sample_ready;
  assign free    = !sample_valid || sample_ready;
  assign proceed = free && ((state == GAP && gap_cnt == GAP_LAST) || state == WAIT_ACK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      div_cnt      <= '0;
      gap_cnt      <= '0;
      bit_cnt      <= '0;
      mask         <= '0;
      addr_ch      <= '0;
      data_ch      <= '0;
      data_valid   <= 1'b0;
      remaining    <= '0;
      shreg        <= '0;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b1;
      adc_din      <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done) busy <= 1'b0;
      if (accept) sample_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start && ch_mask != 8'h00 && !busy) begin
            mask       <= ch_mask;
            addr_ch    <= lowest_ch(ch_mask);
            data_valid <= 1'b0;
            remaining  <= 4'($countones(ch_mask));
            busy       <= 1'b1;
            adc_cs_n   <= 1'b0;
            div_cnt    <= '0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            adc_sclk <= 1'b0;
            adc_din  <= 1'b0;
            state    <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= '0;
            if (!adc_sclk) begin
              adc_sclk <= 1'b1;
              if (bit_cnt >= 4'd4) shreg <= {shreg[10:0], adc_dout};
            end else if (bit_cnt == 4'd15) begin
              adc_cs_n <= 1'b1;
              adc_din  <= 1'b0;
              gap_cnt  <= '0;
              state    <= GAP;
              // The dummy frame of a fresh scan carries a stale conversion and is dropped.
              if (data_valid) begin
                sample_data  <= shreg;
                sample_ch    <= data_ch;
                sample_valid <= 1'b1;
                remaining    <= remaining - 4'd1;
              end
            end else begin
              adc_sclk <= 1'b0;
              bit_cnt  <= bit_cnt + 4'd1;
              adc_din  <= addr_bit(bit_cnt + 4'd1, addr_ch);
            end
          end
        end
        GAP: begin
          if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 8'd1;
          else if (!free) state <= WAIT_ACK;
        end
        WAIT_ACK: begin
        end
        default: state <= IDLE;
      endcase

      // Leaving GAP/WAIT_ACK: next frame, scan restart, or finish.
      if (proceed) begin
        if (remaining == 4'd0 && !(continuous && ch_mask != 8'h00)) begin
          done  <= 1'b1;
          state <= IDLE;
        end else begin
          if (remaining == 4'd0) begin
            mask      <= ch_mask;
            remaining <= 4'($countones(ch_mask));
            addr_ch   <= next_ch(ch_mask, addr_ch);
          end else begin
            addr_ch <= next_ch(mask, addr_ch);
          end
          data_ch    <= addr_ch;
          data_valid <= 1'b1;
          adc_cs_n   <= 1'b0;
          div_cnt    <= '0;
          state      <= SETUP;
        end
      end
    end
  end

endmodule
